deltaw3_calc: RTL and testbench
===============================

Name: deltaw3_calc

Overview:
- Computes the 20 layer-3 weight updates deltaw3_ij = -(a2_i * delta3_j) >>> (FRAC + LR_SHIFT), saturated to 16 bits.
  - i = 1..5 indexes the hidden activations; j = 1..4 indexes the output errors.
- Sits directly upstream of the layer-3 weight bank and drives its deltaw3_11..deltaw3_54 inputs.
- Uses one shared signed multiplier, sequenced by a start/done FSM. All 20 results are presented together, double-buffered, so the weight bank always sees a stable, complete set.

Parameters:
- FRAC, 8: fractional bits of the signed fixed-point format (Q(16-FRAC).FRAC).
- LR_SHIFT, 4: learning rate as a power-of-two right shift (lr = 2^-LR_SHIFT).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to compute a new delta set; honoured only in IDLE.
- clr  input  1  synchronous clear: zeroes every output and every shadow register, forces IDLE.
- a2_1..a2_5  input  16 each, signed  hidden-layer-2 activations.
- delta3_1..delta3_4  input  16 each, signed  output-layer error terms.
- deltaw3_11..deltaw3_54  output  16 each, signed  weight updates. Index order is hidden i, then output j.
- busy  output  1  high while the FSM is in CALC or DONE.
- done  output  1  one-cycle pulse; the new deltaw3 set is valid from this cycle onward.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE; index counter = 0.
  - All deltaw3 outputs = 0; all shadow registers = 0.
  - busy = 0, done = 0.
- States:
  - IDLE: start=1 snapshots a2_1..5 and delta3_1..4 into internal registers, resets k to 0, and moves to CALC.
  - CALC: one entry per cycle for k = 0..19, with j = k/5 + 1 and i = k%5 + 1.
    - Column order: all five entries for output node 1 first, then node 2, and so on.
    - The result is written to shadow[k]; after k = 19 the FSM moves to DONE.
  - DONE: all 20 shadow registers are copied into the output registers on this edge; done = 1 for this one cycle; the next state is IDLE.
- Latency:
  - start sampled high at edge 0.
  - CALC occupies edges 1..20.
  - Outputs update and done asserts after edge 21. busy is high from after edge 0 through the DONE cycle.
- Arithmetic:
  - Form the 32-bit signed product of the snapshots.
  - Arithmetic right-shift by FRAC+LR_SHIFT (floor toward minus infinity, no rounding).
  - Negate in 33 bits.
  - Saturate to the range [-32768, 32767].
- Outputs hold their previous values throughout IDLE and CALC and change only in DONE. The weight bank may therefore sample them on any cycle.
- The snapshot makes input changes during CALC irrelevant; the result reflects the values present at the start edge.
- start while busy is ignored, with no queuing and no restart.
- clr has priority over start and over FSM progress. clr in any state:
  - zeroes outputs and shadows;
  - forces IDLE with busy = 0;
  - suppresses done, so no done pulse follows.
- start and clr high together: clr wins and no computation is launched.
- rst_n asserted mid-CALC: the run is aborted and the full reset state is applied; no done pulse follows release.
- The counter never exceeds 19; no wrap-around is visible outside the block.

Test Plan:
- Basic scaling (FRAC=8, LR_SHIFT=4):
  - Stimulus: reset; a2_1 = 0x0100, delta3_1 = 0x0100, all other inputs 0; pulse start.
  - Required: done exactly 21 cycles after start; deltaw3_11 = 0xFFF0; the other 19 outputs = 0x0000; busy high for 21 cycles.
- Index mapping:
  - Stimulus: a2_i = i*0x0100 for i = 1..5; delta3_j = j*0x0100 for j = 1..4.
  - Required: deltaw3_ij = -(i*j*16). Examples: deltaw3_54 = 0xFEC0; deltaw3_23 = 0xFFA0.
- Saturation and floor (LR_SHIFT=0):
  - a2_1 = 0x7FFF, delta3_1 = 0x7FFF -> deltaw3_11 = 0x8000.
  - a2_1 = 0x7FFF, delta3_1 = 0x8000 -> deltaw3_11 = 0x7FFF.
  - a2_1 = 0xFFFF, delta3_1 = 0x0001 -> deltaw3_11 = 0x0001 (floor to -1, then negated).
- Output stability:
  - Run one set; change inputs and pulse start again.
  - Required: outputs keep the old set for cycles 1..20 and switch only at the second done.
  - A start issued during busy produces no extra done.
- clr mid-CALC:
  - Assert clr for one cycle at CALC k = 10.
  - Required: outputs = 0 on the next edge, busy = 0, no done.
  - A subsequent start computes normally.
- Async reset mid-CALC:
  - Drop rst_n between edges at k = 7.
  - Required: outputs zero immediately without waiting for a clock edge, busy = 0, and no done after release.

Source files
------------

// File: rtl/deltaw3_calc.sv
// Layer-3 weight-update engine: deltaw3_ij = -(a2_i * delta3_j) >>> (FRAC+LR_SHIFT), saturated.
// One shared multiplier walks the 20 entries; results are committed to the outputs together.
module deltaw3_calc #(
    parameter int unsigned FRAC     = 8,
    parameter int unsigned LR_SHIFT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               clr,
    input  logic signed [15:0] a2_1,
    input  logic signed [15:0] a2_2,
    input  logic signed [15:0] a2_3,
    input  logic signed [15:0] a2_4,
    input  logic signed [15:0] a2_5,
    input  logic signed [15:0] delta3_1,
    input  logic signed [15:0] delta3_2,
    input  logic signed [15:0] delta3_3,
    input  logic signed [15:0] delta3_4,
    output logic signed [15:0] deltaw3_11,
    output logic signed [15:0] deltaw3_12,
    output logic signed [15:0] deltaw3_13,
    output logic signed [15:0] deltaw3_14,
    output logic signed [15:0] deltaw3_21,
    output logic signed [15:0] deltaw3_22,
    output logic signed [15:0] deltaw3_23,
    output logic signed [15:0] deltaw3_24,
    output logic signed [15:0] deltaw3_31,
    output logic signed [15:0] deltaw3_32,
    output logic signed [15:0] deltaw3_33,
    output logic signed [15:0] deltaw3_34,
    output logic signed [15:0] deltaw3_41,
    output logic signed [15:0] deltaw3_42,
    output logic signed [15:0] deltaw3_43,
    output logic signed [15:0] deltaw3_44,
    output logic signed [15:0] deltaw3_51,
    output logic signed [15:0] deltaw3_52,
    output logic signed [15:0] deltaw3_53,
    output logic signed [15:0] deltaw3_54,
    output logic               busy,
    output logic               done
);

    localparam int unsigned W     = 16;
    localparam int unsigned PW    = 32;
    localparam int unsigned NW    = 33;
    localparam int unsigned N_I   = 5;
    localparam int unsigned N_J   = 4;
    localparam int unsigned N_K   = 20;
    localparam int unsigned KW    = 5;
    localparam int unsigned IW    = 3;
    localparam int unsigned JW    = 2;
    localparam int unsigned SHIFT = FRAC + LR_SHIFT;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_next;

    logic signed [W-1:0] a2_q     [N_I];
    logic signed [W-1:0] d3_q     [N_J];
    logic signed [W-1:0] shadow_q [N_K];
    logic signed [W-1:0] out_q    [N_K];

    logic [KW-1:0] k_q;
    logic [IW-1:0] i_q;
    logic [JW-1:0] j_q;

    logic snap_en, calc_en, commit_en, last_c;

    logic signed [PW-1:0] prod_c;
    logic signed [PW-1:0] prod_sh_c;
    logic signed [NW-1:0] neg_c;
    logic signed [W-1:0]  sat_c;

    assign last_c = (k_q == KW'(N_K - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Next-state logic; clr overrides everything
    always_comb begin
        state_next = state_q;
        if (clr) begin
            state_next = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_next = CALC;
                CALC:    if (last_c) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Per-state control strobes
    always_comb begin
        snap_en   = 1'b0;
        calc_en   = 1'b0;
        commit_en = 1'b0;
        if (!clr) begin
            case (state_q)
                IDLE:    snap_en   = start;
                CALC:    calc_en   = 1'b1;
                DONE:    commit_en = 1'b1;
                default: ;
            endcase
        end
    end

    // Shared multiplier, floor shift, 33-bit negate and saturation
    always_comb begin
        prod_c    = PW'(a2_q[i_q]) * PW'(d3_q[j_q]);
        prod_sh_c = prod_c >>> SHIFT;
        neg_c     = -(NW'(prod_sh_c));
        if (neg_c > 33'sd32767) begin
            sat_c = 16'sh7FFF;
        end else if (neg_c < -33'sd32768) begin
            sat_c = 16'sh8000;
        end else begin
            sat_c = neg_c[W-1:0];
        end
    end

    // Snapshot, index walk, shadow fill and output commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned n = 0; n < N_I; n++) a2_q[n] <= '0;
            for (int unsigned n = 0; n < N_J; n++) d3_q[n] <= '0;
            for (int unsigned n = 0; n < N_K; n++) begin
                shadow_q[n] <= '0;
                out_q[n]    <= '0;
            end
            k_q  <= '0;
            i_q  <= '0;
            j_q  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else if (clr) begin
            for (int unsigned n = 0; n < N_I; n++) a2_q[n] <= '0;
            for (int unsigned n = 0; n < N_J; n++) d3_q[n] <= '0;
            for (int unsigned n = 0; n < N_K; n++) begin
                shadow_q[n] <= '0;
                out_q[n]    <= '0;
            end
            k_q  <= '0;
            i_q  <= '0;
            j_q  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            done <= commit_en;
            if (snap_en) begin
                a2_q[0] <= a2_1;
                a2_q[1] <= a2_2;
                a2_q[2] <= a2_3;
                a2_q[3] <= a2_4;
                a2_q[4] <= a2_5;
                d3_q[0] <= delta3_1;
                d3_q[1] <= delta3_2;
                d3_q[2] <= delta3_3;
                d3_q[3] <= delta3_4;
                k_q     <= '0;
                i_q     <= '0;
                j_q     <= '0;
            end
            if (calc_en) begin
                shadow_q[k_q] <= sat_c;
                if (!last_c) begin
                    k_q <= k_q + KW'(1);
                    if (i_q == IW'(N_I - 1)) begin
                        i_q <= '0;
                        j_q <= j_q + JW'(1);
                    end else begin
                        i_q <= i_q + IW'(1);
                    end
                end
            end
            if (commit_en) begin
                for (int unsigned n = 0; n < N_K; n++) out_q[n] <= shadow_q[n];
            end
        end
    end

    // Entry k = (j-1)*5 + (i-1)
    assign deltaw3_11 = out_q[0];
    assign deltaw3_21 = out_q[1];
    assign deltaw3_31 = out_q[2];
    assign deltaw3_41 = out_q[3];
    assign deltaw3_51 = out_q[4];
    assign deltaw3_12 = out_q[5];
    assign deltaw3_22 = out_q[6];
    assign deltaw3_32 = out_q[7];
    assign deltaw3_42 = out_q[8];
    assign deltaw3_52 = out_q[9];
    assign deltaw3_13 = out_q[10];
    assign deltaw3_23 = out_q[11];
    assign deltaw3_33 = out_q[12];
    assign deltaw3_43 = out_q[13];
    assign deltaw3_53 = out_q[14];
    assign deltaw3_14 = out_q[15];
    assign deltaw3_24 = out_q[16];
    assign deltaw3_34 = out_q[17];
    assign deltaw3_44 = out_q[18];
    assign deltaw3_54 = out_q[19];

endmodule

// File: tb/tb_deltaw3_calc.sv
// Bench for deltaw3_calc: cycle-level reference model plus directed literal checks.
// A second instance with LR_SHIFT=0 covers saturation and floor behaviour.
module tb_deltaw3_calc;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic start0 = 1'b0;
    logic clr = 1'b0;
    logic signed [15:0] a2 [5];
    logic signed [15:0] d3 [4];
    logic [15:0] q  [20];
    logic [15:0] q0 [20];
    logic busy, done, busy0, done0;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    deltaw3_calc dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clr(clr),
        .a2_1(a2[0]), .a2_2(a2[1]), .a2_3(a2[2]), .a2_4(a2[3]), .a2_5(a2[4]),
        .delta3_1(d3[0]), .delta3_2(d3[1]), .delta3_3(d3[2]), .delta3_4(d3[3]),
        .deltaw3_11(q[0]),  .deltaw3_12(q[5]),  .deltaw3_13(q[10]), .deltaw3_14(q[15]),
        .deltaw3_21(q[1]),  .deltaw3_22(q[6]),  .deltaw3_23(q[11]), .deltaw3_24(q[16]),
        .deltaw3_31(q[2]),  .deltaw3_32(q[7]),  .deltaw3_33(q[12]), .deltaw3_34(q[17]),
        .deltaw3_41(q[3]),  .deltaw3_42(q[8]),  .deltaw3_43(q[13]), .deltaw3_44(q[18]),
        .deltaw3_51(q[4]),  .deltaw3_52(q[9]),  .deltaw3_53(q[14]), .deltaw3_54(q[19]),
        .busy(busy), .done(done)
    );

    deltaw3_calc #(.FRAC(8), .LR_SHIFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .clr(clr),
        .a2_1(a2[0]), .a2_2(a2[1]), .a2_3(a2[2]), .a2_4(a2[3]), .a2_5(a2[4]),
        .delta3_1(d3[0]), .delta3_2(d3[1]), .delta3_3(d3[2]), .delta3_4(d3[3]),
        .deltaw3_11(q0[0]),  .deltaw3_12(q0[5]),  .deltaw3_13(q0[10]), .deltaw3_14(q0[15]),
        .deltaw3_21(q0[1]),  .deltaw3_22(q0[6]),  .deltaw3_23(q0[11]), .deltaw3_24(q0[16]),
        .deltaw3_31(q0[2]),  .deltaw3_32(q0[7]),  .deltaw3_33(q0[12]), .deltaw3_34(q0[17]),
        .deltaw3_41(q0[3]),  .deltaw3_42(q0[8]),  .deltaw3_43(q0[13]), .deltaw3_44(q0[18]),
        .deltaw3_51(q0[4]),  .deltaw3_52(q0[9]),  .deltaw3_53(q0[14]), .deltaw3_54(q0[19]),
        .busy(busy0), .done(done0)
    );

    // Reference arithmetic on wide integers
    function automatic logic [15:0] ref_dw(input logic signed [15:0] a,
                                           input logic signed [15:0] d, input int sh);
        longint p;
        p = longint'(a) * longint'(d);
        p = p >>> sh;
        p = -p;
        if (p > 32767) return 16'h7FFF;
        if (p < -32768) return 16'h8000;
        return 16'(p);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-level model: 21 edges after an accepted start the whole set commits at once
    logic [15:0] m_out [20];
    logic signed [15:0] ma [5];
    logic signed [15:0] md [4];
    logic m_busy, m_done;
    int m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr) begin
            for (int n = 0; n < 20; n++) m_out[n] = 16'h0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_cnt  = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_cnt++;
                if (m_cnt == 21) begin
                    for (int j = 0; j < 4; j++)
                        for (int i = 0; i < 5; i++)
                            m_out[j*5+i] = ref_dw(ma[i], md[j], 12);
                    m_done = 1'b1;
                    m_busy = 1'b0;
                end
            end else if (start) begin
                for (int i = 0; i < 5; i++) ma[i] = a2[i];
                for (int j = 0; j < 4; j++) md[j] = d3[j];
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 16'(busy), 16'(m_busy));
            check("done", 16'(done), 16'(m_done));
            for (int n = 0; n < 20; n++) check($sformatf("dw_k%0d", n), q[n], m_out[n]);
        end
    end

    // Pulse start and wait for done; reports edges after the start edge and busy cycles
    task automatic run_set(input bit inj, input bit chg, output int lat, output int bc,
                           output logic [15:0] mid32, output logic [15:0] mid54);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        bc = 0;
        mid32 = 16'h0;
        mid54 = 16'h0;
        while (!done && lat < 100) begin
            if (busy) bc++;
            if (lat == 10) begin
                mid32 = q[7];
                mid54 = q[19];
            end
            start = inj && (lat == 5);
            if (chg && lat == 3) a2[0] = 16'sh7FFF;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic count_done(input int n, output int dc);
        dc = 0;
        repeat (n) begin
            @(negedge clk);
            if (done) dc++;
        end
    endtask

    task automatic run0(input logic [15:0] a, input logic [15:0] d, input logic [15:0] exp,
                        input string name);
        int t;
        a2[0] = a;
        d3[0] = d;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        t = 0;
        while (!done0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check({name, "_lat"}, 16'(t), 16'd21);
        check(name, q0[0], exp);
    endtask

    initial begin
        int lat, bc, dc;
        logic [15:0] m32, m54;
        for (int i = 0; i < 5; i++) a2[i] = 16'sh0;
        for (int j = 0; j < 4; j++) d3[j] = 16'sh0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_done", 16'(done), 16'h0);
        check("rst_dw11", q[0], 16'h0);
        check("rst_dw54", q[19], 16'h0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Basic scaling
        a2[0] = 16'sh0100;
        d3[0] = 16'sh0100;
        run_set(1'b0, 1'b0, lat, bc, m32, m54);
        check("basic_lat", 16'(lat), 16'd21);
        check("basic_busy_cycles", 16'(bc), 16'd21);
        check("basic_dw11", q[0], 16'hFFF0);
        check("basic_dw21", q[1], 16'h0000);
        check("basic_dw54", q[19], 16'h0000);

        // Index mapping
        for (int i = 0; i < 5; i++) a2[i] = 16'((i + 1) * 256);
        for (int j = 0; j < 4; j++) d3[j] = 16'((j + 1) * 256);
        run_set(1'b0, 1'b0, lat, bc, m32, m54);
        check("map_lat", 16'(lat), 16'd21);
        check("map_dw54", q[19], 16'hFEC0);
        check("map_dw23", q[11], 16'hFFA0);
        check("map_dw32", q[7], 16'hFFA0);
        check("map_dw41", q[3], 16'hFFC0);

        // Stability, ignored start while busy, input change after snapshot, floor
        a2[2] = 16'shFE00;
        d3[1] = 16'sh0180;
        a2[4] = 16'shFFFF;
        d3[3] = 16'sh0001;
        a2[3] = 16'sh0001;
        run_set(1'b1, 1'b1, lat, bc, m32, m54);
        check("stab_lat", 16'(lat), 16'd21);
        check("stab_mid_dw32", m32, 16'hFFA0);
        check("stab_mid_dw54", m54, 16'hFEC0);
        check("stab_dw32", q[7], 16'h0030);
        check("stab_dw31", q[2], 16'h0020);
        check("stab_dw54_floor", q[19], 16'h0001);
        check("stab_dw44", q[18], 16'h0000);
        check("stab_dw11_snap", q[0], 16'hFFF0);
        count_done(30, dc);
        check("stab_no_extra_done", 16'(dc), 16'd0);

        // clr at k = 10
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_busy", 16'(busy), 16'h0);
        check("clr_dw11", q[0], 16'h0);
        check("clr_dw32", q[7], 16'h0);
        count_done(30, dc);
        check("clr_no_done", 16'(dc), 16'd0);
        run_set(1'b0, 1'b0, lat, bc, m32, m54);
        check("post_clr_lat", 16'(lat), 16'd21);
        check("post_clr_dw11", q[0], 16'hF801);

        // Async reset at k = 7
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", 16'(busy), 16'h0);
        check("arst_dw11", q[0], 16'h0);
        check("arst_dw32", q[7], 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        count_done(30, dc);
        check("arst_no_done", 16'(dc), 16'd0);

        // Saturation and floor with LR_SHIFT = 0
        run0(16'h7FFF, 16'h7FFF, 16'h8000, "sat_pos");
        run0(16'h7FFF, 16'h8000, 16'h7FFF, "sat_neg");
        run0(16'hFFFF, 16'h0001, 16'h0001, "floor_m1");

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
